// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encodings,
// default halt/bubble words and the J-type opcode shared with the hazard unit.
`default_nettype none

package if_stage_pkg;

  typedef enum logic [0:0] {
    IF_FETCH = 1'b0,
    IF_HALT  = 1'b1
  } if_state_e;

  localparam logic [31:0] DEF_HALT_INST = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_NOP_INST  = 32'h0000_0000;
  localparam logic [5:0]  INST_J_TYPE   = 6'b000010;

  function automatic logic [31:0] pc_plus4(input logic [31:0] p);
    return p + 32'd4;
  endfunction

  function automatic logic is_j_type(input logic [31:0] inst);
    return inst[31:26] == INST_J_TYPE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_perf_cnt.sv
// if_perf_cnt: wrapping fetch/stall event counters for the fetch stage.
// Only instantiated when IF_PERF_CNT_EN is defined.
`default_nettype none

module if_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch_inc,
  input  logic        i_stall_inc,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt
);

  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (i_fetch_inc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (i_stall_inc) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// if_stage: PC register, IF/ID pipeline register and instruction-memory request.
// Optional macro IF_PERF_CNT_EN adds fetch_cnt / stall_cnt outputs.
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = DEF_HALT_INST,
  parameter logic [31:0] NOP_INST  = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nWrite_PC,
  input  logic        nWrite_IF_ID,
  input  logic        flush_IF_ID,
  input  logic [31:0] j_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_IF_ID,
  output logic [31:0] pc4_IF_ID,
  output logic        valid_IF_ID,
  output logic [31:0] pc,
  output logic        halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  if_state_e   r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_pc4, w_pc4_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] w_pc_plus4;
  logic        w_is_halt;

  assign w_pc_plus4 = pc_plus4(r_pc);
  assign w_is_halt  = (imem_rdata == HALT_INST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IF_FETCH;
      r_pc    <= RESET_PC;
      r_inst  <= NOP_INST;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
      r_pc4   <= w_pc4_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_pc4_nxt   = r_pc4;
    w_valid_nxt = r_valid;
    case (r_state)
      IF_FETCH: begin
        if (nWrite_IF_ID) begin
          // Stall: keep everything; the J (if any) stays in ID and re-flushes later.
          w_pc_nxt = r_pc;
        end else if (flush_IF_ID) begin
          if (!nWrite_PC) w_pc_nxt = j_target;
          w_inst_nxt  = NOP_INST;
          w_pc4_nxt   = 32'd0;
          w_valid_nxt = 1'b0;
        end else if (imem_ready) begin
          w_inst_nxt  = imem_rdata;
          w_pc4_nxt   = w_pc_plus4;
          w_valid_nxt = 1'b1;
          if (w_is_halt) begin
            w_state_nxt = IF_HALT;
          end else if (!nWrite_PC) begin
            w_pc_nxt = w_pc_plus4;
          end
        end else begin
          w_inst_nxt  = NOP_INST;
          w_pc4_nxt   = 32'd0;
          w_valid_nxt = 1'b0;
        end
      end
      IF_HALT: begin
        if (!nWrite_IF_ID) begin
          w_inst_nxt  = NOP_INST;
          w_pc4_nxt   = 32'd0;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IF_FETCH;
      end
    endcase
  end

  assign imem_req    = (r_state == IF_FETCH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign inst_IF_ID  = r_inst;
  assign pc4_IF_ID   = r_pc4;
  assign valid_IF_ID = r_valid;
  assign halted      = (r_state == IF_HALT);

`ifdef IF_PERF_CNT_EN
  logic w_fetch_inc;
  logic w_stall_inc;

  assign w_fetch_inc = (r_state == IF_FETCH) && !nWrite_IF_ID && !flush_IF_ID && imem_ready;
  assign w_stall_inc = (r_state == IF_FETCH) && (nWrite_IF_ID || !imem_ready);

  if_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_fetch_inc (w_fetch_inc),
    .i_stall_inc (w_stall_inc),
    .o_fetch_cnt (fetch_cnt),
    .o_stall_cnt (stall_cnt)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// tb_if_stage: directed + randomized checks of if_stage against a cycle-level
// behavioural model of the fetch rules.
`default_nettype none

module tb_if_stage;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_W  = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        nWrite_PC;
  logic        nWrite_IF_ID;
  logic        flush_IF_ID;
  logic [31:0] j_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst_IF_ID;
  logic [31:0] pc4_IF_ID;
  logic        valid_IF_ID;
  logic [31:0] pc;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .nWrite_PC    (nWrite_PC),
    .nWrite_IF_ID (nWrite_IF_ID),
    .flush_IF_ID  (flush_IF_ID),
    .j_target     (j_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .inst_IF_ID   (inst_IF_ID),
    .pc4_IF_ID    (pc4_IF_ID),
    .valid_IF_ID  (valid_IF_ID),
    .pc           (pc),
    .halted       (halted)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc    = 32'd0;
  logic [31:0] m_inst  = NOP_W;
  logic [31:0] m_pc4   = 32'd0;
  logic        m_valid = 1'b0;
  logic        m_halt  = 1'b0;
  logic [31:0] m_fetch = 32'd0;
  logic [31:0] m_stall = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bubble();
    m_inst  = NOP_W;
    m_pc4   = 32'd0;
    m_valid = 1'b0;
  endtask

  task automatic step(input logic r, input logic nwpc, input logic nwif, input logic fl,
                      input logic [31:0] jt, input logic rdy, input logic [31:0] rd);
    @(negedge clk);
    rst          = r;
    nWrite_PC    = nwpc;
    nWrite_IF_ID = nwif;
    flush_IF_ID  = fl;
    j_target     = jt;
    imem_ready   = rdy;
    imem_rdata   = rd;
    #1;
    chk("imem_req", {31'd0, imem_req}, {31'd0, !m_halt});
    chk("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    if (r) begin
      m_pc = 32'd0; bubble(); m_halt = 1'b0; m_fetch = 32'd0; m_stall = 32'd0;
    end else if (!m_halt) begin
      if (nwif || !rdy) m_stall = m_stall + 32'd1;
      if (nwif) begin
        // nothing moves
      end else if (fl) begin
        if (!nwpc) m_pc = jt;
        bubble();
      end else if (rdy) begin
        m_fetch = m_fetch + 32'd1;
        m_inst  = rd;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        if (rd == HALT_W) m_halt = 1'b1;
        else if (!nwpc) m_pc = m_pc + 32'd4;
      end else begin
        bubble();
      end
    end else if (!nwif) begin
      bubble();
    end
    #1;
    chk("pc", pc, m_pc);
    chk("inst_IF_ID", inst_IF_ID, m_inst);
    chk("pc4_IF_ID", pc4_IF_ID, m_pc4);
    chk("valid_IF_ID", {31'd0, valid_IF_ID}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, m_fetch);
    chk("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  initial begin
    logic r, nwpc, nwif, fl, rdy;
    logic [31:0] jt, rd;
    rst = 1'b1; nWrite_PC = 1'b0; nWrite_IF_ID = 1'b0; flush_IF_ID = 1'b0;
    j_target = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;

    // Reset, then back-to-back fetches
    step(1, 0, 0, 0, 32'd0, 1, 32'h1234_5678);
    step(1, 0, 0, 0, 32'd0, 0, 32'd0);
    chk("reset_pc", pc, 32'd0);
    chk("reset_valid", {31'd0, valid_IF_ID}, 32'd0);
    step(0, 0, 0, 0, 32'd0, 1, 32'h2008_0001);
    step(0, 0, 0, 0, 32'd0, 1, 32'h2009_0002);
    chk("seq_pc8", pc, 32'd8);
    chk("seq_pc4_8", pc4_IF_ID, 32'd8);

    // Memory wait cycles at pc=8
    repeat (3) step(0, 0, 0, 0, 32'd0, 0, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 32'd0, 1, 32'h200A_0003);
    chk("wait_pc", pc, 32'h0000_000C);

    // Load-use stall at pc=0xC
    step(0, 1, 1, 0, 32'd0, 1, 32'h1111_1111);
    chk("stall_inst", inst_IF_ID, 32'h200A_0003);
    step(0, 0, 0, 0, 32'd0, 1, 32'h200B_0004);

    // Flush wins over a fetched halt word
    step(0, 0, 0, 1, 32'h0000_0040, 1, HALT_W);
    chk("flush_pc", pc, 32'h0000_0040);
    step(0, 0, 0, 1, 32'h0000_0010, 0, 32'd0);

    // Halt at pc=0x10; flush and stalls ignored afterwards
    step(0, 0, 0, 0, 32'd0, 1, HALT_W);
    chk("halt_inst", inst_IF_ID, HALT_W);
    step(0, 0, 1, 1, 32'h0000_0080, 1, 32'd5);
    step(0, 0, 0, 1, 32'h0000_0080, 1, 32'd5);
    step(0, 0, 0, 0, 32'd0, 1, 32'd5);
    step(1, 0, 0, 0, 32'd0, 1, 32'd5);

    // Stall blocks a pending flush for one cycle
    step(0, 1, 1, 1, 32'h0000_0200, 1, 32'd7);
    chk("stall_noredir", pc, 32'd0);
    step(0, 0, 0, 1, 32'h0000_0200, 0, 32'd0);

    // PC wrap and unaligned target pass-through
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'd0);
    step(0, 0, 0, 0, 32'd0, 1, 32'h2222_2222);
    chk("wrap_pc4", pc4_IF_ID, 32'd0);
    step(0, 0, 0, 1, 32'h0000_0043, 0, 32'd0);
    step(0, 0, 0, 0, 32'd0, 1, 32'h3333_3333);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      r    = ($urandom_range(63) == 0);
      nwif = ($urandom_range(5) == 0);
      nwpc = ($urandom_range(15) == 0) ? ~nwif : nwif;
      fl   = ($urandom_range(7) == 0);
      rdy  = ($urandom_range(2) != 0);
      jt   = $urandom;
      rd   = ($urandom_range(24) == 0) ? HALT_W : $urandom;
      step(r, nwpc, nwif, fl, jt, rdy, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
